ripple_count_monitor: RTL

- Consumes the 4-bit output `q` of `ripple_carry_counter` and sits directly downstream of it.
- Samples `q` on the rising edge of `clk`; the counter updates on the falling edge, so `q` is stable at sampling time.
- Checks that `q` advances by exactly +1 mod 16 per clock, and reports lock, wrap events and step errors.
- Declares a fault on persistent misbehaviour, e.g. a stuck or broken ripple stage.

---
 rtl/ripple_count_monitor.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ripple_count_monitor.sv
// Step monitor for a 4-bit ripple counter: checks q advances by +1 mod 16 each clk,
// reports lock, wraps and step errors, and latches a fault on persistent misbehaviour.
module ripple_count_monitor #(
    parameter int unsigned WRAP_W    = 8,
    parameter int unsigned ERR_W     = 8,
    parameter int unsigned LOCK_N    = 4,
    parameter int unsigned ERR_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        q,
    input  logic              clr_err,
    output logic              locked,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              fault,
    output logic [3:0]        last_q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SYNC  = 2'd1;
    localparam logic [1:0] S_TRACK = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam int unsigned RUN_W = 4;

    logic [1:0]        r_state;
    logic              r_locked;
    logic              r_wrap;
    logic [WRAP_W-1:0] r_wrap_cnt;
    logic              r_err;
    logic [ERR_W-1:0]  r_err_cnt;
    logic              r_fault;
    logic [3:0]        r_last_q;
    logic [RUN_W-1:0]  r_good_run;
    logic [RUN_W-1:0]  r_miss_run;

    logic [1:0]        w_state_nxt;
    logic              w_locked_nxt;
    logic              w_wrap_nxt;
    logic [WRAP_W-1:0] w_wrap_cnt_nxt;
    logic              w_err_nxt;
    logic [ERR_W-1:0]  w_err_cnt_nxt;
    logic              w_fault_nxt;
    logic [RUN_W-1:0]  w_good_run_nxt;
    logic [RUN_W-1:0]  w_miss_run_nxt;

    logic              w_step_ok;
    logic [RUN_W-1:0]  w_good_inc;
    logic [RUN_W-1:0]  w_miss_inc;

    // An unknown q makes the compare non-true, so it lands on the bad-step path.
    assign w_step_ok  = (q == 4'(r_last_q + 4'd1));
    assign w_good_inc = RUN_W'(r_good_run + RUN_W'(1));
    assign w_miss_inc = RUN_W'(r_miss_run + RUN_W'(1));

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_locked   <= 1'b0;
            r_wrap     <= 1'b0;
            r_wrap_cnt <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
            r_fault    <= 1'b0;
            r_last_q   <= 4'd0;
            r_good_run <= '0;
            r_miss_run <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_locked   <= w_locked_nxt;
            r_wrap     <= w_wrap_nxt;
            r_wrap_cnt <= w_wrap_cnt_nxt;
            r_err      <= w_err_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_fault    <= w_fault_nxt;
            r_last_q   <= q;
            r_good_run <= w_good_run_nxt;
            r_miss_run <= w_miss_run_nxt;
        end
    end

    // Next-state and next-output evaluation for one observed step.
    always_comb begin
        w_state_nxt    = r_state;
        w_locked_nxt   = r_locked;
        w_wrap_nxt     = 1'b0;
        w_wrap_cnt_nxt = r_wrap_cnt;
        w_err_nxt      = r_err;
        w_err_cnt_nxt  = r_err_cnt;
        w_fault_nxt    = r_fault;
        w_good_run_nxt = r_good_run;
        w_miss_run_nxt = r_miss_run;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_SYNC;
            end
            S_SYNC: begin
                if (w_step_ok) begin
                    if (w_good_inc == RUN_W'(LOCK_N)) begin
                        w_state_nxt    = S_TRACK;
                        w_locked_nxt   = 1'b1;
                        w_good_run_nxt = '0;
                    end else begin
                        w_good_run_nxt = w_good_inc;
                    end
                end else begin
                    w_good_run_nxt = '0;
                end
            end
            S_TRACK: begin
                if (w_step_ok) begin
                    w_miss_run_nxt = '0;
                    if (r_last_q == 4'd15) begin
                        w_wrap_nxt = 1'b1;
                        if (r_wrap_cnt != {WRAP_W{1'b1}})
                            w_wrap_cnt_nxt = WRAP_W'(r_wrap_cnt + WRAP_W'(1));
                    end
                end else if (!clr_err) begin
                    w_err_nxt = 1'b1;
                    if (r_err_cnt != {ERR_W{1'b1}})
                        w_err_cnt_nxt = ERR_W'(r_err_cnt + ERR_W'(1));
                    w_miss_run_nxt = w_miss_inc;
                    if (w_miss_inc == RUN_W'(ERR_LIMIT)) begin
                        w_state_nxt  = S_FAULT;
                        w_locked_nxt = 1'b0;
                        w_fault_nxt  = 1'b1;
                    end
                end
            end
            S_FAULT: begin
                if (clr_err) begin
                    w_state_nxt    = S_SYNC;
                    w_fault_nxt    = 1'b0;
                    w_good_run_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (clr_err) begin
            w_err_nxt      = 1'b0;
            w_err_cnt_nxt  = '0;
            w_miss_run_nxt = '0;
        end
    end

    assign locked   = r_locked;
    assign wrap     = r_wrap;
    assign wrap_cnt = r_wrap_cnt;
    assign err      = r_err;
    assign err_cnt  = r_err_cnt;
    assign fault    = r_fault;
    assign last_q   = r_last_q;

endmodule
